// File: rtl/cpu_rdresp_serializer.sv
// Two-entry line FIFO that breaks cache read-response lines into 32-bit words.
// Each line is emitted lane 0 .. last, one word per CPU handshake.
module cpu_rdresp_serializer #(
  parameter int LANES     = 4,
  parameter int LANESBITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [LANES*32-1:0]    i_line_data,
  input  logic [LANESBITS-1:0]   i_line_last,
  input  logic                   i_line_lp_id,
  input  logic                   i_line_valid,
  output logic                   o_line_ready,
  output logic [31:0]            o_word_data,
  output logic                   o_word_lp_id,
  output logic [LANESBITS-1:0]   o_word_lane,
  output logic                   o_word_last,
  output logic                   o_word_valid,
  input  logic                   i_word_ready
);

  logic [LANES*32-1:0]  data_q [2];
  logic [LANESBITS-1:0] last_q [2];
  logic                 lp_q   [2];
  logic                 wr_ptr;
  logic                 rd_ptr;
  logic [1:0]           count;
  logic [LANESBITS-1:0] lane_q;

  logic push;
  logic word_hs;
  logic pop;

  // Both handshakes are qualified by reset so nothing moves while it is held.
  assign o_line_ready = reset && (count != 2'd2);
  assign o_word_valid = reset && (count != 2'd0);

  assign push    = i_line_valid && o_line_ready;
  assign word_hs = o_word_valid && i_word_ready;
  assign pop     = word_hs && o_word_last;

  assign o_word_data  = data_q[rd_ptr][{lane_q, 5'd0} +: 32];
  assign o_word_lane  = lane_q;
  assign o_word_lp_id = lp_q[rd_ptr];
  assign o_word_last  = (lane_q == last_q[rd_ptr]);

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
      lane_q <= '0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      if (word_hs) lane_q <= pop ? '0 : lane_q + 1'b1;
    end
  end

  // Line storage is deliberately not reset; it is only read while occupied.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr] <= i_line_data;
      last_q[wr_ptr] <= i_line_last;
      lp_q[wr_ptr]   <= i_line_lp_id;
    end
  end

endmodule
